// File: rtl/physics_step_scheduler.sv
// physics_step_scheduler
// Per-frame sequencer that time-shares one collision/resolver datapath
// across N_OBJ OBB registers. A synchronized frame tick clears the impulse
// accumulators, every unordered pair (i<j) is then presented to the shared
// datapath in lexicographic order, and a single commit pulse loads all
// obb_reg instances at the end of the frame.
//
// Optional build macro: PHYSICS_STATIC_SKIP_EN
//   When defined, pairs whose two objects are both flagged in static_mask
//   (captured once during CLEAR) are skipped without spending settle or
//   sample cycles. When undefined, static_mask is ignored.
module physics_step_scheduler #(
    parameter int N_OBJ  = 4,
    parameter int IDX_W  = 2,
    parameter int SETTLE = 2
) (
    input  logic             clk,
    input  logic             reset_rtl_0,
    input  logic             enable,
    input  logic             frame_tick,
    input  logic             is_collision,
    input  logic [N_OBJ-1:0] static_mask,
    output logic [IDX_W-1:0] sel_a,
    output logic [IDX_W-1:0] sel_b,
    output logic             acc_clr,
    output logic             acc_en,
    output logic             commit,
    output logic             busy,
    output logic [7:0]       hit_count,
    output logic [7:0]       overrun_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_SETTLE_WAIT,
        S_SAMPLE,
        S_COMMIT
    } state_e;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

    // Tick synchronizer: [0],[1] are the metastability pair, [2] the edge delay.
    logic [2:0]       sync_q, sync_d;
    logic             tick_rise_q, tick_rise_d;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] sel_a_q, sel_a_d;
    logic [IDX_W-1:0] sel_b_q, sel_b_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [7:0]       hit_acc_q, hit_acc_d;
    logic [7:0]       hit_count_q, hit_count_d;
    logic [7:0]       overrun_q, overrun_d;
    logic             acc_clr_q, acc_clr_d;
    logic             commit_q, commit_d;
    logic             busy_q, busy_d;

    // Pair search results: first pair of a frame, and the pair after the current one.
    logic [N_OBJ-1:0] first_mask, skip_mask;
    logic             first_found, adv_found;
    logic [IDX_W-1:0] first_a, first_b, adv_a, adv_b;

`ifdef PHYSICS_STATIC_SKIP_EN
    logic [N_OBJ-1:0] mask_q, mask_d;

    // CLEAR looks at the live mask; the rest of the frame uses the captured copy.
    assign first_mask = static_mask;
    assign skip_mask  = mask_q;

    // Static flags are frozen for the whole frame at CLEAR.
    always_comb begin
        mask_d = mask_q;
        if (state_q == S_CLEAR) begin
            mask_d = static_mask;
        end
    end

    // Captured static flags.
    always_ff @(posedge clk or negedge reset_rtl_0) begin
        if (!reset_rtl_0) begin
            mask_q <= '0;
        end else begin
            mask_q <= mask_d;
        end
    end
`else
    logic unused_static_mask;

    // No pair is ever skipped in this build.
    assign unused_static_mask = ^static_mask;
    assign first_mask         = '0;
    assign skip_mask          = '0;
`endif

    // Lexicographic pair search; with empty masks this reduces to the plain
    // "bump sel_b, else bump sel_a and restart sel_b" walk.
    always_comb begin
        first_found = 1'b0;
        first_a     = '0;
        first_b     = '0;
        adv_found   = 1'b0;
        adv_a       = '0;
        adv_b       = '0;
        for (int i = 0; i < N_OBJ - 1; i++) begin
            for (int j = i + 1; j < N_OBJ; j++) begin
                if (!first_found && !(first_mask[i] && first_mask[j])) begin
                    first_found = 1'b1;
                    first_a     = IDX_W'(i);
                    first_b     = IDX_W'(j);
                end
                if (!adv_found && !(skip_mask[i] && skip_mask[j]) &&
                    ((IDX_W'(i) > sel_a_q) ||
                     ((IDX_W'(i) == sel_a_q) && (IDX_W'(j) > sel_b_q)))) begin
                    adv_found = 1'b1;
                    adv_a     = IDX_W'(i);
                    adv_b     = IDX_W'(j);
                end
            end
        end
    end

    // Synchronizer shift and registered rising-edge detect of frame_tick.
    always_comb begin
        sync_d      = {sync_q[1:0], frame_tick};
        tick_rise_d = sync_q[1] & ~sync_q[2];
    end

    // Frame sequencer next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        sel_a_d     = sel_a_q;
        sel_b_d     = sel_b_q;
        cnt_d       = cnt_q;
        hit_acc_d   = hit_acc_q;
        hit_count_d = hit_count_q;
        overrun_d   = overrun_q;
        acc_clr_d   = 1'b0;
        commit_d    = 1'b0;

        // A tick during an active frame (COMMIT included) is dropped, not queued.
        if (tick_rise_q && busy_q && (overrun_q != 8'hFF)) begin
            overrun_d = overrun_q + 8'd1;
        end

        case (state_q)
            S_IDLE: begin
                if (tick_rise_q && enable) begin
                    state_d   = S_CLEAR;
                    acc_clr_d = 1'b1;
                    sel_a_d   = '0;
                    sel_b_d   = IDX_W'(1);
                    cnt_d     = '0;
                    hit_acc_d = '0;
                end
            end
            S_CLEAR: begin
                if (first_found) begin
                    state_d = S_SETTLE_WAIT;
                    sel_a_d = first_a;
                    sel_b_d = first_b;
                    cnt_d   = '0;
                end else begin
                    state_d  = S_COMMIT;
                    commit_d = 1'b1;
                end
            end
            S_SETTLE_WAIT: begin
                if (cnt_q == SETTLE_LAST) begin
                    state_d = S_SAMPLE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_SAMPLE: begin
                if (is_collision && (hit_acc_q != 8'hFF)) begin
                    hit_acc_d = hit_acc_q + 8'd1;
                end
                if (adv_found) begin
                    state_d = S_SETTLE_WAIT;
                    sel_a_d = adv_a;
                    sel_b_d = adv_b;
                    cnt_d   = '0;
                end else begin
                    state_d  = S_COMMIT;
                    commit_d = 1'b1;
                end
            end
            S_COMMIT: begin
                hit_count_d = hit_acc_q;
                state_d     = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State, selects, counters and pulse outputs.
    always_ff @(posedge clk or negedge reset_rtl_0) begin
        if (!reset_rtl_0) begin
            sync_q      <= '0;
            tick_rise_q <= 1'b0;
            state_q     <= S_IDLE;
            sel_a_q     <= '0;
            sel_b_q     <= IDX_W'(1);
            cnt_q       <= '0;
            hit_acc_q   <= '0;
            hit_count_q <= '0;
            overrun_q   <= '0;
            acc_clr_q   <= 1'b0;
            commit_q    <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            sync_q      <= sync_d;
            tick_rise_q <= tick_rise_d;
            state_q     <= state_d;
            sel_a_q     <= sel_a_d;
            sel_b_q     <= sel_b_d;
            cnt_q       <= cnt_d;
            hit_acc_q   <= hit_acc_d;
            hit_count_q <= hit_count_d;
            overrun_q   <= overrun_d;
            acc_clr_q   <= acc_clr_d;
            commit_q    <= commit_d;
            busy_q      <= busy_d;
        end
    end

    assign sel_a       = sel_a_q;
    assign sel_b       = sel_b_q;
    assign acc_clr     = acc_clr_q;
    assign commit      = commit_q;
    assign busy        = busy_q;
    assign hit_count   = hit_count_q;
    assign overrun_cnt = overrun_q;
    // is_collision is only meaningful during SAMPLE, so the enable is gated
    // from the registered state in that same cycle while the selects still hold.
    assign acc_en      = (state_q == S_SAMPLE) && is_collision;

endmodule

// File: tb/tb_physics_step_scheduler.sv
// Bench for physics_step_scheduler (default build, 4 objects, SETTLE=2).
module tb_physics_step_scheduler;

    localparam int N_OBJ  = 4;
    localparam int IDX_W  = 2;
    localparam int SETTLE = 2;

    logic             clk;
    logic             reset_rtl_0;
    logic             enable;
    logic             frame_tick;
    logic             is_collision;
    logic [N_OBJ-1:0] static_mask;
    logic [IDX_W-1:0] sel_a, sel_b;
    logic             acc_clr, acc_en, commit, busy;
    logic [7:0]       hit_count, overrun_cnt;

    typedef struct {
        int a;
        int b;
        int en;
    } pair_t;

    pair_t      sb_q[$];
    logic [5:0] coll_mask;
    int         n_checks;
    int         n_fail;

    physics_step_scheduler #(
        .N_OBJ  (N_OBJ),
        .IDX_W  (IDX_W),
        .SETTLE (SETTLE)
    ) dut (
        .clk          (clk),
        .reset_rtl_0  (reset_rtl_0),
        .enable       (enable),
        .frame_tick   (frame_tick),
        .is_collision (is_collision),
        .static_mask  (static_mask),
        .sel_a        (sel_a),
        .sel_b        (sel_b),
        .acc_clr      (acc_clr),
        .acc_en       (acc_en),
        .commit       (commit),
        .busy         (busy),
        .hit_count    (hit_count),
        .overrun_cnt  (overrun_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int pair_index(input int a, input int b);
        int idx;
        idx = 0;
        for (int k = 0; k < a; k++) idx += N_OBJ - 1 - k;
        return idx + (b - a - 1);
    endfunction

    // Stand-in for the shared collision detector: collides on the chosen pairs.
    always_comb begin
        is_collision = 1'b0;
        if (sel_b > sel_a) is_collision = coll_mask[pair_index(int'(sel_a), int'(sel_b))];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic start_frame(output bit ok);
        int lat;
        ok  = 1'b0;
        lat = -1;
        frame_tick = 1'b1;
        repeat (3) @(negedge clk);
        frame_tick = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (acc_clr === 1'b1) begin
                ok  = 1'b1;
                lat = k;
                break;
            end
        end
        check("frame_start", 32'(ok), 1);
        if (ok) check("tick_latency", 32'(lat), 0);
    endtask

    task automatic idle_watch(input int n, output int busy_n, output int commit_n);
        busy_n   = 0;
        commit_n = 0;
        repeat (n) begin
            @(negedge clk);
            if (busy === 1'b1) busy_n++;
            if (commit === 1'b1) commit_n++;
        end
    endtask

    task automatic run_frame(input logic [5:0] cm, input int tick_at, input int exp_ovr);
        bit    ok;
        int    ens, commits, exp_hits, exp_ens, p;
        pair_t e;
        coll_mask = cm;
        start_frame(ok);
        if (!ok) return;
        sb_q.delete();
        exp_hits = 0;
        p = 0;
        for (int a = 0; a < N_OBJ - 1; a++) begin
            for (int b = a + 1; b < N_OBJ; b++) begin
                e.a  = a;
                e.b  = b;
                e.en = int'(cm[p]);
                sb_q.push_back(e);
                exp_hits += e.en;
                p++;
            end
        end
        exp_ens = exp_hits;
        ens     = 0;
        commits = 0;
        check("c0_busy", 32'(busy), 1);
        check("c0_sel_a", 32'(sel_a), 0);
        check("c0_sel_b", 32'(sel_b), 1);
        for (int c = 0; c <= 20; c++) begin
            if (c > 0) @(negedge clk);
            if (c == tick_at) frame_tick = 1'b1;
            if (c == tick_at + 3) frame_tick = 1'b0;
            if (acc_en === 1'b1) ens++;
            if (commit === 1'b1) commits++;
            if (c > 0 && c <= 18 && (c % (SETTLE + 1)) == 0) begin
                check("sb_nonempty", 32'(sb_q.size() != 0), 1);
                if (sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    check($sformatf("c%0d_sel_a", c), 32'(sel_a), 32'(e.a));
                    check($sformatf("c%0d_sel_b", c), 32'(sel_b), 32'(e.b));
                    check($sformatf("c%0d_acc_en", c), 32'(acc_en), 32'(e.en));
                end
            end
            if (c == 19) begin
                check("c19_commit", 32'(commit), 1);
                check("c19_busy", 32'(busy), 1);
            end
            if (c == 20) begin
                check("c20_busy", 32'(busy), 0);
                check("hit_count", 32'(hit_count), 32'(exp_hits));
                check("acc_en_total", 32'(ens), 32'(exp_ens));
                check("commit_total", 32'(commits), 1);
                check("overrun_cnt", 32'(overrun_cnt), 32'(exp_ovr));
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int busy_n, commit_n;
        n_checks    = 0;
        n_fail      = 0;
        reset_rtl_0 = 1'b0;
        enable      = 1'b1;
        frame_tick  = 1'b0;
        static_mask = 4'b0011;
        coll_mask   = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_sel_a", 32'(sel_a), 0);
        check("rst_sel_b", 32'(sel_b), 1);
        check("rst_busy", 32'(busy), 0);
        check("rst_pulses", 32'({acc_clr, acc_en, commit}), 0);
        check("rst_hit_count", 32'(hit_count), 0);
        check("rst_overrun", 32'(overrun_cnt), 0);
        reset_rtl_0 = 1'b1;
        repeat (2) @(negedge clk);

        // Plain frame, no collisions
        run_frame(6'b000000, -1, 0);
        // Single hit on pair (1,3)
        run_frame(6'b010000, -1, 0);
        // Hits on (0,1),(0,3),(2,3) with an overlapping tick at cycle 10
        run_frame(6'b100101, 10, 1);
        idle_watch(15, busy_n, commit_n);
        check("no_queued_busy", 32'(busy_n), 0);
        check("no_queued_commit", 32'(commit_n), 0);

        // enable low: three ticks ignored, no overrun
        enable = 1'b0;
        busy_n = 0;
        repeat (3) begin
            frame_tick = 1'b1;
            repeat (3) begin
                @(negedge clk);
                if (busy === 1'b1) busy_n++;
            end
            frame_tick = 1'b0;
            repeat (5) begin
                @(negedge clk);
                if (busy === 1'b1) busy_n++;
            end
        end
        check("disabled_busy", 32'(busy_n), 0);
        check("disabled_overrun", 32'(overrun_cnt), 1);
        check("disabled_hits_kept", 32'(hit_count), 3);
        enable = 1'b1;
        run_frame(6'b111111, -1, 1);

        // Asynchronous reset in the middle of a frame
        begin
            bit ok;
            coll_mask = 6'b111111;
            start_frame(ok);
            repeat (8) @(negedge clk);
            check("pre_abort_busy", 32'(busy), 1);
            #2;
            reset_rtl_0 = 1'b0;
            #1;
            check("abort_busy", 32'(busy), 0);
            check("abort_sel_a", 32'(sel_a), 0);
            check("abort_sel_b", 32'(sel_b), 1);
            check("abort_pulses", 32'({acc_clr, acc_en, commit}), 0);
            check("abort_hit_count", 32'(hit_count), 0);
            check("abort_overrun", 32'(overrun_cnt), 0);
            @(negedge clk);
            reset_rtl_0 = 1'b1;
            idle_watch(25, busy_n, commit_n);
            check("post_abort_commit", 32'(commit_n), 0);
            check("post_abort_busy", 32'(busy_n), 0);
        end
        run_frame(6'b000001, -1, 0);

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
